// File: rtl/instr_mem_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
// master = loader side, slave = host link / memory side.
interface instr_mem_loader_if #(
  parameter int ADDR_W = 6
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  modport master (
    input  rx_data, rx_valid,
    output rx_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output rx_data, rx_valid,
    input  rx_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/instr_mem_loader.sv
// Loads a program from a byte stream into the instruction memory, MSB-first per word.
// Optional trailing XOR checksum byte when INSTR_LOADER_CHECKSUM_EN is defined.
module instr_mem_loader #(
  parameter int ADDR_W      = 6,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  instr_mem_loader_if.master bus,
  output logic               busy_o,
  output logic               cpu_hold_o,
  output logic               done_o,
  output logic               err_o
);
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int CNT_W  = ADDR_W + 1;
  localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_DATA, S_WRITE, S_CHK, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  nwords_q, nwords_d;
  logic [CNT_W-1:0]  wcnt_q, wcnt_d;
  logic [1:0]        bidx_q, bidx_d;
  logic [23:0]       shift_q, shift_d;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
`ifdef INSTR_LOADER_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  logic              xfer;
  logic              stall_st;
  logic              tmo;
  logic [ADDR_W-1:0] hdr_low;
  logic [CNT_W-1:0]  hdr_n;
  logic [CNT_W-1:0]  wcnt_inc;
  logic [31:0]       word_in;

  assign stall_st = (state_q == S_HDR) || (state_q == S_DATA) || (state_q == S_CHK);
  assign xfer     = bus.rx_valid && stall_st;
  assign tmo      = stall_st && !xfer && (idle_q == IDLE_W'(TIMEOUT_CYC - 1));
  // A zero length field means a full-depth program.
  assign hdr_low  = bus.rx_data[ADDR_W-1:0];
  assign hdr_n    = (hdr_low == '0) ? CNT_W'(DEPTH) : {1'b0, hdr_low};
  assign wcnt_inc = wcnt_q + CNT_W'(1);
  assign word_in  = {shift_q, bus.rx_data};

  always_comb begin
    state_d  = state_q;
    nwords_d = nwords_q;
    wcnt_d   = wcnt_q;
    bidx_d   = bidx_q;
    shift_d  = shift_q;
    idle_d   = '0;
    err_d    = err_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
`ifdef INSTR_LOADER_CHECKSUM_EN
    csum_d   = csum_q;
`endif

    if (stall_st && !xfer) begin
      idle_d = idle_q + IDLE_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_HDR;
          err_d   = 1'b0;
          wcnt_d  = '0;
          bidx_d  = '0;
          shift_d = '0;
`ifdef INSTR_LOADER_CHECKSUM_EN
          csum_d  = '0;
`endif
        end
      end
      S_HDR: begin
        if (xfer) begin
          nwords_d = hdr_n;
          wcnt_d   = '0;
          bidx_d   = '0;
          state_d  = S_DATA;
`ifdef INSTR_LOADER_CHECKSUM_EN
          csum_d   = bus.rx_data;
`endif
        end
      end
      S_DATA: begin
        if (xfer) begin
          shift_d = word_in[23:0];
          bidx_d  = bidx_q + 2'd1;
`ifdef INSTR_LOADER_CHECKSUM_EN
          csum_d  = csum_q ^ bus.rx_data;
`endif
          if (bidx_q == 2'd3) begin
            addr_d  = wcnt_q[ADDR_W-1:0];
            wdata_d = word_in;
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        wcnt_d = wcnt_inc;
        if (wcnt_inc == nwords_q) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
          state_d = S_CHK;
`else
          state_d = S_DONE;
`endif
        end else begin
          state_d = S_DATA;
        end
      end
      S_CHK: begin
`ifdef INSTR_LOADER_CHECKSUM_EN
        if (xfer) begin
          if (bus.rx_data != csum_q) err_d = 1'b1;
          state_d = S_DONE;
        end
`else
        state_d = S_IDLE;
`endif
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Stalled link: abandon the load, keep what was already written.
    if (tmo) begin
      state_d = S_IDLE;
      err_d   = 1'b1;
      idle_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      nwords_q <= '0;
      wcnt_q   <= '0;
      bidx_q   <= '0;
      shift_q  <= '0;
      idle_q   <= '0;
      err_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
`ifdef INSTR_LOADER_CHECKSUM_EN
      csum_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      nwords_q <= nwords_d;
      wcnt_q   <= wcnt_d;
      bidx_q   <= bidx_d;
      shift_q  <= shift_d;
      idle_q   <= idle_d;
      err_q    <= err_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
`ifdef INSTR_LOADER_CHECKSUM_EN
      csum_q   <= csum_d;
`endif
    end
  end

  assign bus.rx_ready  = stall_st;
  assign bus.mem_we    = (state_q == S_WRITE);
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign busy_o        = stall_st || (state_q == S_WRITE);
  assign cpu_hold_o    = busy_o;
  assign done_o        = (state_q == S_DONE);
  assign err_o         = err_q;
endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: table of short loads plus hand-written
// sequences for full-depth load, gaps, timeout, reset mid-load and checksum.
module tb_instr_mem_loader;
  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic busy, cpu_hold, done, err;

  instr_mem_loader_if #(.ADDR_W(6)) bus ();

  instr_mem_loader #(.ADDR_W(6), .TIMEOUT_CYC(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (start),
    .bus       (bus),
    .busy_o    (busy),
    .cpu_hold_o(cpu_hold),
    .done_o    (done),
    .err_o     (err)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  // Write / done monitor: only this block writes these.
  int         cap_n    = 0;
  int         done_cnt = 0;
  int         rdy_we   = 0;
  logic [5:0]  cap_addr [0:511];
  logic [31:0] cap_data [0:511];

  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      if (cap_n < 512) begin
        cap_addr[cap_n] = bus.mem_addr;
        cap_data[cap_n] = bus.mem_wdata;
      end
      cap_n = cap_n + 1;
      if (bus.rx_ready === 1'b1) rdy_we = rdy_we + 1;
    end
    if (done === 1'b1) done_cnt = done_cnt + 1;
  end

  logic [31:0] prog [0:63];

  typedef struct {
    logic [7:0]  hdr;
    logic [31:0] w0;
    logic [31:0] w1;
    int          exp_n;
  } vec_t;
  vec_t vecs [0:4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit acc;
    int n;
    repeat (gap) begin @(posedge clk); #1; end
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 64) begin
      @(negedge clk);
      acc = bus.rx_ready;
      @(posedge clk);
      n++;
    end
    #1 bus.rx_valid = 1'b0;
    if (!acc) begin
      tot_cnt++;
      $display("FAIL byte_accept: byte %h not accepted within 64 cycles", b);
    end
  endtask

  task automatic wait_idle();
    bit b;
    int n;
    n = 0;
    b = 1'b1;
    while (b && n < 100) begin
      @(negedge clk);
      b = busy;
      @(posedge clk); #1;
      n++;
    end
    if (b) begin
      tot_cnt++;
      $display("FAIL wait_idle: busy still 1 after 100 cycles");
    end
  endtask

  task automatic run_load(input logic [7:0] hdr, input int nw, input int gap);
`ifdef INSTR_LOADER_CHECKSUM_EN
    logic [7:0] cs;
    cs = hdr;
`endif
    pulse_start();
    send_byte(hdr, gap);
    for (int w = 0; w < nw; w++) begin
      for (int k = 0; k < 4; k++) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
        cs = cs ^ prog[w][31-8*k -: 8];
`endif
        send_byte(prog[w][31-8*k -: 8], gap);
      end
    end
`ifdef INSTR_LOADER_CHECKSUM_EN
    send_byte(cs, gap);
`endif
    wait_idle();
  endtask

  task automatic check_load(input string name, input int cap0, input int done0, input int nw);
    int bad;
    check({name, "_nwrites"}, cap_n - cap0, nw);
    bad = 0;
    for (int i = 0; i < nw && cap0 + i < 512; i++) begin
      if (cap_addr[cap0+i] !== 6'(i) || cap_data[cap0+i] !== prog[i]) begin
        bad++;
        if (bad == 1)
          $display("FAIL %s_word%0d: got addr %0d data %h expected addr %0d data %h",
                   name, i, cap_addr[cap0+i], cap_data[cap0+i], i, prog[i]);
      end
    end
    check({name, "_words"}, bad, 0);
    check({name, "_done"}, done_cnt - done0, 1);
    check({name, "_err"}, err, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, d0, r0;

    vecs[0] = '{hdr: 8'h01, w0: 32'hDEADBEEF, w1: 32'h0,        exp_n: 1};
    vecs[1] = '{hdr: 8'h41, w0: 32'h12345678, w1: 32'h0,        exp_n: 1};
    vecs[2] = '{hdr: 8'hC1, w0: 32'h00000000, w1: 32'h0,        exp_n: 1};
    vecs[3] = '{hdr: 8'h02, w0: 32'hFFFFFFFF, w1: 32'h00000000, exp_n: 2};
    vecs[4] = '{hdr: 8'h82, w0: 32'h0F0F0F0F, w1: 32'hF0F0F0F0, exp_n: 2};

    rst_n        = 1'b0;
    start        = 1'b0;
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_cpu_hold", cpu_hold, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_mem_we", bus.mem_we, 1'b0);
    check("rst_rx_ready", bus.rx_ready, 1'b0);
    check("rst_mem_addr", bus.mem_addr, 6'd0);
    check("rst_mem_wdata", bus.mem_wdata, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Table of short loads
    for (int v = 0; v < 5; v++) begin
      prog[0] = vecs[v].w0;
      prog[1] = vecs[v].w1;
      c0 = cap_n; d0 = done_cnt;
      run_load(vecs[v].hdr, vecs[v].exp_n, v % 3);
      check_load($sformatf("vec%0d", v), c0, d0, vecs[v].exp_n);
    end

    // Basic two-word program, back-to-back bytes
    prog[0] = 32'h80080001;
    prog[1] = 32'h00078000;
    c0 = cap_n; d0 = done_cnt; r0 = rdy_we;
    run_load(8'h02, 2, 0);
    check_load("basic", c0, d0, 2);
    check("basic_ready_in_write", rdy_we - r0, 0);

    // Full-depth load
    for (int i = 0; i < 64; i++) prog[i] = {8'(i), 8'(i + 1), ~8'(i), 8'hC3};
    c0 = cap_n; d0 = done_cnt;
    run_load(8'h00, 64, 0);
    check_load("full", c0, d0, 64);

    // Gapped stream
    prog[0] = 32'h80080001;
    prog[1] = 32'h00078000;
    c0 = cap_n; d0 = done_cnt; r0 = rdy_we;
    run_load(8'h02, 2, 3);
    check_load("gaps", c0, d0, 2);
    check("gaps_ready_in_write", rdy_we - r0, 0);

    // start during a load must not restart it
    prog[0] = 32'h11223344;
    c0 = cap_n; d0 = done_cnt;
    pulse_start();
    send_byte(8'h01, 0);
    pulse_start();
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    send_byte(8'h33, 0);
    send_byte(8'h44, 0);
`ifdef INSTR_LOADER_CHECKSUM_EN
    send_byte(8'h01 ^ 8'h11 ^ 8'h22 ^ 8'h33 ^ 8'h44, 0);
`endif
    wait_idle();
    check_load("start_busy", c0, d0, 1);

    // Timeout after header and two bytes
    c0 = cap_n; d0 = done_cnt;
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'hAB, 0);
    send_byte(8'hCD, 0);
    repeat (15) @(posedge clk);
    #1;
    check("tmo_busy_before", busy, 1'b1);
    check("tmo_cpu_hold_before", cpu_hold, 1'b1);
    check("tmo_err_before", err, 1'b0);
    @(posedge clk); #1;
    check("tmo_busy_after", busy, 1'b0);
    check("tmo_err_after", err, 1'b1);
    check("tmo_rx_ready_after", bus.rx_ready, 1'b0);
    check("tmo_no_write", cap_n - c0, 0);
    check("tmo_no_done", done_cnt - d0, 0);
    pulse_start();
    check("start_clears_err", err, 1'b0);
    wait_idle();

    // Reset in the middle of the second word
    pulse_start();
    send_byte(8'h02, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    send_byte(8'hCC, 0);
    send_byte(8'hDD, 0);
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    check("mid_wdata_before", bus.mem_wdata, 32'hAABBCCDD);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_err", err, 1'b0);
    check("mid_rst_rx_ready", bus.rx_ready, 1'b0);
    check("mid_rst_wdata", bus.mem_wdata, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    prog[0] = 32'h80080001;
    prog[1] = 32'h00078000;
    c0 = cap_n; d0 = done_cnt;
    run_load(8'h02, 2, 0);
    check_load("after_rst", c0, d0, 2);

`ifdef INSTR_LOADER_CHECKSUM_EN
    // Checksum good, then bad
    prog[0] = 32'h00000001;
    c0 = cap_n; d0 = done_cnt;
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    wait_idle();
    check_load("chk_good", c0, d0, 1);
    c0 = cap_n; d0 = done_cnt;
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h01, 0);
    send_byte(8'h55, 0);
    wait_idle();
    check("chk_bad_done", done_cnt - d0, 1);
    check("chk_bad_err", err, 1'b1);
    check("chk_bad_write", cap_n - c0, 1);
`endif

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
